id_ex_hazard_ctrl: RTL and testbench

//  Hazard/sequencing controller for the ID/EX stage boundary of the 5-stage MIPS pipeline.

---
 rtl/id_ex_hazard_ctrl.sv | 112 +++++++++++
 tb/tb_id_ex_hazard_ctrl.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/id_ex_hazard_ctrl.sv
// ID/EX hazard controller for the 5-stage MIPS pipeline: load-use and MDU-busy stalls,
// taken-branch flushes, and a saturating stall-cycle counter.
module id_ex_hazard_ctrl #(
  parameter int REG_AW  = 5,
  parameter int MDU_LAT = 4,
  parameter int CNT_W   = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              id_valid,
  input  logic [REG_AW-1:0] id_rs,
  input  logic [REG_AW-1:0] id_rt,
  input  logic              id_uses_rt,
  input  logic              id_is_mdu,
  input  logic              id_reads_hilo,
  input  logic              ex_mem_read,
  input  logic [REG_AW-1:0] ex_rt,
  input  logic              ex_branch_taken,
  output logic              pc_we,
  output logic              ifid_we,
  output logic              ifid_flush,
  output logic              idex_bubble,
  output logic              mdu_busy,
  output logic [CNT_W-1:0]  stall_cnt
);

  localparam int MDU_CW = (MDU_LAT < 1) ? 1 : $clog2(MDU_LAT + 1);
  localparam logic [MDU_CW-1:0] MDU_LOAD = MDU_CW'(MDU_LAT);
  localparam logic [MDU_CW-1:0] MDU_ONE  = MDU_CW'(1);

  localparam logic [0:0] RUN      = 1'b0;
  localparam logic [0:0] MDU_WAIT = 1'b1;

  logic [0:0]        state_q, state_d;
  logic [MDU_CW-1:0] mdu_cnt_q, mdu_cnt_d;
  logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;

  logic busy;
  logic lu_haz;
  logic mdu_haz;
  logic mdu_issue;

  assign busy     = (mdu_cnt_q != '0);
  assign mdu_busy = reset & busy;

  // Register $0 is hard-wired to zero, so a load targeting it is never a real dependency.
  assign lu_haz  = id_valid & ex_mem_read & (ex_rt != '0) &
                   ((ex_rt == id_rs) | (id_uses_rt & (ex_rt == id_rt)));
  assign mdu_haz = id_valid & (id_is_mdu | id_reads_hilo) & busy;

  always_comb begin
    pc_we       = 1'b1;
    ifid_we     = 1'b1;
    ifid_flush  = 1'b0;
    idex_bubble = 1'b0;
    if (!reset) begin
      pc_we       = 1'b0;
      ifid_we     = 1'b0;
      ifid_flush  = 1'b1;
      idex_bubble = 1'b1;
    end else if (ex_branch_taken) begin
      ifid_flush  = 1'b1;
      idex_bubble = 1'b1;
    end else if (mdu_haz | lu_haz) begin
      pc_we       = 1'b0;
      ifid_we     = 1'b0;
      idex_bubble = 1'b1;
    end
  end

  // Only a mult/div that actually moves into EX starts the busy window.
  assign mdu_issue = reset & id_valid & id_is_mdu & ~ex_branch_taken & ~mdu_haz & ~lu_haz;

  // A taken branch leaves the counter alone: the op in flight is older than the branch.
  always_comb begin
    mdu_cnt_d = mdu_cnt_q;
    if (mdu_issue) begin
      mdu_cnt_d = MDU_LOAD;
    end else if (busy) begin
      mdu_cnt_d = mdu_cnt_q - MDU_ONE;
    end
  end

  always_comb begin
    state_d = RUN;
    if (!ex_branch_taken && (mdu_haz || state_q == MDU_WAIT)) begin
      state_d = (mdu_cnt_q > MDU_ONE) ? MDU_WAIT : RUN;
    end
  end

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (!pc_we && stall_cnt_q != '1) begin
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= RUN;
      mdu_cnt_q   <= '0;
      stall_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      mdu_cnt_q   <= mdu_cnt_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_id_ex_hazard_ctrl.sv
// Bench for id_ex_hazard_ctrl: directed vectors, a per-cycle reference model of the
// stall/flush rules, and literal spot checks on the key cycles.
module tb_id_ex_hazard_ctrl;

  localparam int REG_AW    = 5;
  localparam int MDU_LAT   = 4;
  localparam int CNT_W     = 4;
  localparam int STALL_MAX = (1 << CNT_W) - 1;

  logic              clk = 1'b0;
  logic              reset = 1'b0;
  logic              id_valid = 1'b0;
  logic [REG_AW-1:0] id_rs = '0;
  logic [REG_AW-1:0] id_rt = '0;
  logic              id_uses_rt = 1'b0;
  logic              id_is_mdu = 1'b0;
  logic              id_reads_hilo = 1'b0;
  logic              ex_mem_read = 1'b0;
  logic [REG_AW-1:0] ex_rt = '0;
  logic              ex_branch_taken = 1'b0;
  logic              pc_we, ifid_we, ifid_flush, idex_bubble, mdu_busy;
  logic [CNT_W-1:0]  stall_cnt;

  int checks = 0;
  int errors = 0;
  int mRemaining = 0;
  int mStall = 0;
  bit cmpEnable = 1'b1;

  id_ex_hazard_ctrl #(.REG_AW(REG_AW), .MDU_LAT(MDU_LAT), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
    .id_uses_rt(id_uses_rt), .id_is_mdu(id_is_mdu), .id_reads_hilo(id_reads_hilo),
    .ex_mem_read(ex_mem_read), .ex_rt(ex_rt), .ex_branch_taken(ex_branch_taken),
    .pc_we(pc_we), .ifid_we(ifid_we), .ifid_flush(ifid_flush), .idex_bubble(idex_bubble),
    .mdu_busy(mdu_busy), .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  // Expected {pc_we, ifid_we, ifid_flush, idex_bubble} from the pipeline rules.
  function automatic logic [3:0] expRow();
    bit loadUse, mduWait;
    loadUse = id_valid && ex_mem_read && ex_rt != 0 &&
              (ex_rt == id_rs || (id_uses_rt && ex_rt == id_rt));
    mduWait = id_valid && (id_is_mdu || id_reads_hilo) && mRemaining > 0;
    if (!reset)               return 4'b0011;
    else if (ex_branch_taken) return 4'b1111;
    else if (mduWait || loadUse) return 4'b0001;
    else                      return 4'b1100;
  endfunction

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      errors++;
      $display("[TB] FAIL %s at %0t: got %0d expected %0d", name, $time, actual, expected);
    end
  endtask

  // Reference model: MDU busy cycles remaining and saturating stall tally.
  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      mRemaining <= 0;
      mStall     <= 0;
    end else begin
      logic [3:0] row;
      row = expRow();
      if (row[3] == 1'b0 && mStall < STALL_MAX) mStall <= mStall + 1;
      if (id_valid && id_is_mdu && row == 4'b1100) mRemaining <= MDU_LAT;
      else if (mRemaining > 0) mRemaining <= mRemaining - 1;
    end
  end

  always @(negedge clk) begin
    if (cmpEnable) begin
      logic [3:0] row;
      row = expRow();
      checkOutput("pc_we", pc_we, row[3]);
      checkOutput("ifid_we", ifid_we, row[2]);
      checkOutput("ifid_flush", ifid_flush, row[1]);
      checkOutput("idex_bubble", idex_bubble, row[0]);
      checkOutput("mdu_busy", mdu_busy, (reset && mRemaining > 0) ? 1 : 0);
      checkOutput("stall_cnt", stall_cnt, mStall);
    end
  end

  // Drive one cycle's inputs just after the rising edge, return at the falling edge.
  task automatic applyStimulus(input bit valid, input int rs, input int rt, input bit usesRt,
                               input bit isMdu, input bit readsHilo, input bit memRead,
                               input int exRt, input bit branch);
    @(posedge clk);
    #1;
    id_valid        = valid;
    id_rs           = REG_AW'(rs);
    id_rt           = REG_AW'(rt);
    id_uses_rt      = usesRt;
    id_is_mdu       = isMdu;
    id_reads_hilo   = readsHilo;
    ex_mem_read     = memRead;
    ex_rt           = REG_AW'(exRt);
    ex_branch_taken = branch;
    @(negedge clk);
  endtask

  task automatic idle();
    applyStimulus(1, 1, 2, 1, 0, 0, 0, 0, 0);
  endtask

  initial begin
    repeat (2) @(negedge clk);
    checkOutput("rst_pc_we", pc_we, 0);
    checkOutput("rst_ifid_flush", ifid_flush, 1);
    checkOutput("rst_idex_bubble", idex_bubble, 1);
    checkOutput("rst_stall_cnt", stall_cnt, 0);
    #2 reset = 1'b1;

    // Load-use on rs: one stall cycle
    applyStimulus(1, 8, 2, 0, 0, 0, 1, 8, 0);
    checkOutput("lu_pc_we", pc_we, 0);
    checkOutput("lu_bubble", idex_bubble, 1);
    applyStimulus(1, 8, 2, 0, 0, 0, 0, 0, 0);
    checkOutput("lu_after_pc_we", pc_we, 1);
    checkOutput("lu_after_stall_cnt", stall_cnt, 1);

    // $0 target and unused rt never stall; used rt does
    applyStimulus(1, 0, 2, 0, 0, 0, 1, 0, 0);
    checkOutput("r0_pc_we", pc_we, 1);
    applyStimulus(1, 3, 8, 0, 0, 0, 1, 8, 0);
    checkOutput("rt_unused_bubble", idex_bubble, 0);
    applyStimulus(1, 3, 8, 1, 0, 0, 1, 8, 0);
    checkOutput("rt_used_pc_we", pc_we, 0);

    // mult issues, following mfhi waits out the busy window
    applyStimulus(1, 4, 5, 1, 1, 0, 0, 0, 0);
    checkOutput("mult_issue_pc_we", pc_we, 1);
    for (int i = 0; i < MDU_LAT; i++) begin
      applyStimulus(1, 0, 0, 0, 0, 1, 0, 0, 0);
      checkOutput("mfhi_wait_busy", mdu_busy, 1);
      checkOutput("mfhi_wait_pc_we", pc_we, 0);
    end
    applyStimulus(1, 0, 0, 0, 0, 1, 0, 0, 0);
    checkOutput("mfhi_issue_pc_we", pc_we, 1);
    checkOutput("mfhi_issue_busy", mdu_busy, 0);
    checkOutput("mfhi_issue_stall_cnt", stall_cnt, 6);

    // Branch overrides load-use, no stall counted
    applyStimulus(1, 8, 2, 0, 0, 0, 1, 8, 1);
    checkOutput("br_lu_pc_we", pc_we, 1);
    checkOutput("br_lu_flush", ifid_flush, 1);
    checkOutput("br_lu_bubble", idex_bubble, 1);
    idle();
    checkOutput("br_lu_stall_cnt", stall_cnt, 6);

    // Flushed mult never starts the MDU
    applyStimulus(1, 4, 5, 1, 1, 0, 0, 0, 1);
    applyStimulus(1, 0, 0, 0, 0, 1, 0, 0, 0);
    checkOutput("flushed_mult_busy", mdu_busy, 0);
    checkOutput("mflo_no_stall", pc_we, 1);

    // Reset in the middle of an MDU wait with two busy cycles left
    applyStimulus(1, 4, 5, 1, 1, 0, 0, 0, 0);
    applyStimulus(1, 0, 0, 0, 0, 1, 0, 0, 0);
    applyStimulus(1, 0, 0, 0, 0, 1, 0, 0, 0);
    applyStimulus(1, 0, 0, 0, 0, 1, 0, 0, 0);
    checkOutput("pre_rst_busy", mdu_busy, 1);
    #1 reset = 1'b0;
    #1;
    checkOutput("mid_rst_busy", mdu_busy, 0);
    checkOutput("mid_rst_pc_we", pc_we, 0);
    checkOutput("mid_rst_flush", ifid_flush, 1);
    checkOutput("mid_rst_stall_cnt", stall_cnt, 0);
    #1 reset = 1'b1;
    applyStimulus(1, 0, 0, 0, 0, 1, 0, 0, 0);
    checkOutput("post_rst_pc_we", pc_we, 1);

    // Branch during MDU wait keeps the op in flight
    applyStimulus(1, 4, 5, 1, 1, 0, 0, 0, 0);
    applyStimulus(1, 0, 0, 0, 0, 1, 0, 0, 0);
    applyStimulus(1, 0, 0, 0, 0, 1, 0, 0, 1);
    checkOutput("br_in_wait_pc_we", pc_we, 1);
    applyStimulus(1, 0, 0, 0, 0, 1, 0, 0, 0);
    checkOutput("br_kept_busy", mdu_busy, 1);
    repeat (3) idle();

    // Stall counter saturates and holds
    for (int i = 0; i < STALL_MAX + 5; i++) applyStimulus(1, 9, 2, 0, 0, 0, 1, 9, 0);
    idle();
    checkOutput("stall_sat", stall_cnt, STALL_MAX);
    idle();
    checkOutput("stall_sat_hold", stall_cnt, STALL_MAX);

    cmpEnable = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
